// File: rtl/gpio_pkg.sv
// gpio_pkg: register map offsets shared by the GPIO port and its bench.
package gpio_pkg;

    // Offsets from the port's base address.
    localparam int unsigned OFF_DDR      = 0;
    localparam int unsigned OFF_PIN      = 1;
    localparam int unsigned OFF_PORT     = 2;
    localparam int unsigned OFF_PORT_SET = 3;
    localparam int unsigned OFF_PORT_CLR = 4;
    localparam int unsigned OFF_PORT_TGL = 5;
    localparam int unsigned OFF_RISE_EN  = 6;
    localparam int unsigned OFF_FALL_EN  = 7;
    localparam int unsigned OFF_IRQ_STAT = 8;

    // Number of decoded offsets; anything at or beyond this is unmapped.
    localparam int unsigned REG_COUNT    = 9;

endpackage

// File: rtl/gpio_in_sync.sv
// gpio_in_sync: one pad bit's two-flop synchroniser and edge detector.
// The history flop trails the synchronised value by one cycle, so an edge
// is flagged for exactly one cycle. armed_i masks edges while the chain
// is still filling after reset.
module gpio_in_sync (
    input  logic clk,
    input  logic arst_n,
    input  logic pad_i,
    input  logic armed_i,
    output logic pin_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronise the pad and keep one cycle of history for edge compare.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pin_o  = sync2_q;
    assign rise_o =  sync2_q & ~prev_q & armed_i;
    assign fall_o = ~sync2_q &  prev_q & armed_i;

endmodule

// File: rtl/gpio_irq_port.sv
// gpio_irq_port: memory-mapped GPIO port with per-bit direction, atomic
// set/clear/toggle of the output latch, synchronised inputs, and sticky
// rise/fall edge status feeding one level interrupt.
//
// Bus protocol: there is no valid/ready handshake. A write is accepted
// unconditionally at the posedge where we=1 and addr decodes to a register;
// a read is a pure combinational function of addr and returns the current
// register value (never the value being written in the same cycle).
module gpio_irq_port
    import gpio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 128
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [WIDTH-1:0]  d_in,
    output logic [WIDTH-1:0]  d_out,
    output logic              irq,
    inout  wire  [WIDTH-1:0]  io
);

    logic [WIDTH-1:0] ddr_q,     ddr_d;
    logic [WIDTH-1:0] port_q,    port_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] stat_q,    stat_d;
    logic [1:0]       arm_cnt_q, arm_cnt_d;

    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] stat_set;
    logic [WIDTH-1:0] stat_clr;
    logic             armed;

    // Offset relative to the base. An address below the base wraps to a
    // large offset, so a single unsigned compare covers both ends of the
    // window as long as the map fits below the top of the address space.
    logic [ADDR_W-1:0] off;
    logic              hit;

    assign off = addr - ADDR_W'(BASE_ADDR);
    assign hit = (off < ADDR_W'(REG_COUNT));

    logic wr_ddr, wr_port, wr_set, wr_clr, wr_tgl, wr_rise, wr_fall, wr_stat;

    assign wr_ddr  = we && (off == ADDR_W'(OFF_DDR));
    assign wr_port = we && (off == ADDR_W'(OFF_PORT));
    assign wr_set  = we && (off == ADDR_W'(OFF_PORT_SET));
    assign wr_clr  = we && (off == ADDR_W'(OFF_PORT_CLR));
    assign wr_tgl  = we && (off == ADDR_W'(OFF_PORT_TGL));
    assign wr_rise = we && (off == ADDR_W'(OFF_RISE_EN));
    assign wr_fall = we && (off == ADDR_W'(OFF_FALL_EN));
    assign wr_stat = we && (off == ADDR_W'(OFF_IRQ_STAT));

    // Edges are ignored until three clocks after reset release, which is
    // long enough for the sync chain and history flop to hold pad values.
    assign armed = (arm_cnt_q == 2'd3);

    // Pad drivers and per-bit input synchronisers.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign io[i] = ddr_q[i] ? port_q[i] : 1'bz;

        gpio_in_sync u_sync (
            .clk     (clk),
            .arst_n  (arst_n),
            .pad_i   (io[i]),
            .armed_i (armed),
            .pin_o   (pin[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    // New status comes from enabled edges; a W1C write can only clear bits
    // that are not being set in the same cycle, so a set always wins.
    assign stat_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign stat_clr = wr_stat ? d_in : '0;

    // Register next-state from bus writes, edge status and the arm counter.
    always_comb begin
        ddr_d     = ddr_q;
        port_d    = port_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        stat_d    = (stat_q & ~stat_clr) | stat_set;
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;

        if (wr_ddr)  ddr_d     = d_in;
        if (wr_rise) rise_en_d = d_in;
        if (wr_fall) fall_en_d = d_in;

        if (wr_port) port_d = d_in;
        if (wr_set)  port_d = port_q | d_in;
        if (wr_clr)  port_d = port_q & ~d_in;
        if (wr_tgl)  port_d = port_q ^ d_in;
    end

    // State registers; reset releases the pads and restarts the arm count.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ddr_q     <= '0;
            port_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            arm_cnt_q <= 2'd0;
        end else begin
            ddr_q     <= ddr_d;
            port_q    <= port_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    // Combinational read mux; strobe-only registers and unmapped offsets read 0.
    always_comb begin
        d_out = '0;
        if (hit) begin
            case (off)
                ADDR_W'(OFF_DDR):      d_out = ddr_q;
                ADDR_W'(OFF_PIN):      d_out = pin;
                ADDR_W'(OFF_PORT):     d_out = port_q;
                ADDR_W'(OFF_RISE_EN):  d_out = rise_en_q;
                ADDR_W'(OFF_FALL_EN):  d_out = fall_en_q;
                ADDR_W'(OFF_IRQ_STAT): d_out = stat_q;
                default:               d_out = '0;
            endcase
        end
    end

    assign irq = |stat_q;

endmodule

// File: doc/gpio_irq_port.md
Name: gpio_irq_port

Overview:
Parametrised memory-mapped GPIO port with per-bit direction, atomic set/clear/toggle of the output latch, and a two-flop input synchroniser. Adds per-bit rising/falling edge detection with sticky write-1-to-clear status and a single level interrupt output. Sits on the core data bus at BASE_ADDR and drives bidirectional pads.

Parameters:
WIDTH, 8, number of IO bits and the data bus width
ADDR_W, 8, bus address width
BASE_ADDR, 128, address of register offset 0

Ports:
clk  input  1  clock; all state changes on posedge
arst_n  input  1  reset, asynchronous, active-low
addr  input  ADDR_W  bus address
we  input  1  write strobe, one write per cycle
d_in  input  WIDTH  write data
d_out  output  WIDTH  read data, combinational from addr
irq  output  1  interrupt, OR of (IRQ_STAT), flop-derived
io  inout  WIDTH  pads; bit driven by PORT[i] when DDR[i]=1, else Z

Behaviour:
- Register map (offset from BASE_ADDR; R = read, W = write):
  0 DDR, RW.
  1 PIN, R: synchronised pads; writes ignored.
  2 PORT, RW.
  3 PORT_SET, W1S to PORT; reads 0.
  4 PORT_CLR, W1C to PORT; reads 0.
  5 PORT_TGL, W1-toggle PORT; reads 0.
  6 RISE_EN, RW.
  7 FALL_EN, RW.
  8 IRQ_STAT, R/W1C.
- Addresses outside BASE_ADDR..BASE_ADDR+8: writes ignored, no state change; d_out=0.
- Writes take effect at the posedge where we=1. Reads are combinational with zero latency and return the current register value, not the value being written.
- Reset: DDR, PORT, RISE_EN, FALL_EN and IRQ_STAT = 0; sync1, sync2 and prev = 0; arm counter = 0.
  - Consequences: irq=0, all io = Z, d_out = 0 unless PIN is addressed.
- Input path per bit: sync1 <= io; sync2 <= sync1; prev <= sync2.
  - PIN = sync2.
  - A pad change seen before posedge N is visible in PIN after posedge N+1.
- Edge detection per bit:
  - rise = sync2 & ~prev & armed; fall = ~sync2 & prev & armed.
  - IRQ_STAT[i] is set at posedge N+2 if (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
  - irq is high after posedge N+2.
- Arm counter: 2-bit, saturating, counts from 0 after reset release. armed = (count==3).
  - Edges are suppressed for the first 3 cycles so sync-chain fill after reset raises no false status.
- IRQ_STAT write: bits written with 1 clear, bits written with 0 keep their value.
  - A set and a clear on the same bit in the same cycle: set wins, bit stays 1.
- Enable gating: clearing RISE_EN/FALL_EN does not clear already-set IRQ_STAT bits.
  - Enables are sampled in the cycle the edge is detected.
- Output loopback: with DDR[i]=1, PIN[i] follows PORT[i] 2 cycles later.
  - This loopback can raise edge status, by design, used for software-triggered interrupts.
- PORT updates:
  - SET: PORT | d_in.
  - CLR: PORT & ~d_in.
  - TGL: PORT ^ d_in.
  - Writing 0 leaves PORT unchanged.
- Reset asserted mid-operation: all state clears asynchronously, io releases to Z immediately, and the arm counter restarts.

Decomposition:
- Package gpio_pkg: register offset constants (OFF_DDR..OFF_IRQ_STAT = 0..8) and REG_COUNT = 9.
- One sub-module, gpio_in_sync. Instantiate it WIDTH times. Per bit it holds:
  - sync1, sync2 and prev flops;
  - rise/fall outputs;
  - an `armed` input.
- Pad tristate, decode, registers and arm counter stay in the top module.

Test Plan:
- Reset, then read all 9 addresses -> every read is 0x00, io all Z, irq=0. Write 0xFF to address 140 -> no register changes.
- Write DDR=0x0F and PORT=0xA5 -> io[3:0]=4'h5, io[7:4]=Z. PIN[3:0]=4'h5 two cycles later. Write PORT_SET=0x02 -> PORT=0xA7. PORT_CLR=0x81 -> PORT=0x26. PORT_TGL=0xFF -> PORT=0xD9.
- Hold io[7:4] (external input bits, DDR=0) = 4'hF through reset release. Wait 5 cycles with RISE_EN=0xFF -> IRQ_STAT=0x00 and irq=0, because the arm counter suppresses edges.
- RISE_EN=0x10, FALL_EN=0x20. Drive io[4] 0->1 before posedge N -> PIN[4]=1 after N+1, IRQ_STAT=0x10 and irq=1 after N+2. Drive io[5] 1->0 -> IRQ_STAT=0x30.
- Write IRQ_STAT=0x10 -> IRQ_STAT=0x20. Write 0x20 in the same cycle as a new fall edge on io[5] -> bit stays 1. Write 0x20 again -> 0x00 and irq=0.
- DDR=0x01, RISE_EN=0x01, write PORT_SET=0x01 -> IRQ_STAT[0]=1 after 3 cycles (loopback). Assert arst_n low mid-run -> all registers 0 and io Z immediately.
